imem_loader: RTL and testbench

Byte-stream writer for the core's instruction memory, feeding the word store that the fetch stage reads. It accepts a framed little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes those words to consecutive instruction-RAM addresses starting at 0 and holds the CPU in reset while a load is in progress.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that writes 32-bit words into instruction memory
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds trailing XOR checksum byte and CSUM state)
module imem_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Largest accepted word count; 17 bits so a full 16-bit depth still fits.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [16:0]        words_left_q, words_left_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        word_q, word_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               loading;
    logic               xfer;
    logic [15:0]        len_n;

    // Status and handshake outputs are pure functions of the current state.
    always_comb begin
        loading    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
        byte_ready = loading;
        busy       = loading;
        cpu_hold   = loading;
        done       = (state_q == S_DONE);
        error      = (state_q == S_ERR);
        mem_we     = we_q;
        mem_addr   = waddr_q;
        mem_wdata  = wdata_q;
        xfer       = byte_valid && loading;
        len_n      = {byte_data, len_lo_q};
    end

    // Next-state and datapath updates; everything holds unless a transfer or start moves it.
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        addr_d       = addr_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    addr_d     = '0;
                    byte_idx_d = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = byte_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if ((len_n == 16'd0) || ({1'b0, len_n} > DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        words_left_d = {1'b0, len_n};
                        state_d      = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ byte_data;
`endif
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = byte_data;
                        2'd1: word_d[15:8]  = byte_data;
                        2'd2: word_d[23:16] = byte_data;
                        default: begin
                            // Fourth byte completes the word: issue the write next cycle.
                            we_d         = 1'b1;
                            waddr_d      = addr_q;
                            wdata_d      = {byte_data, word_q};
                            addr_d       = addr_q + 1'b1;
                            words_left_d = words_left_q - 17'd1;
                            if (words_left_q == 17'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = S_CSUM;
`else
                                state_d = S_DONE;
`endif
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) begin
                    state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any load without a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_lo_q     <= 8'd0;
            words_left_q <= 17'd0;
            byte_idx_q   <= 2'd0;
            word_q       <= 24'd0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with randomized framed loads
module tb_imem_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [31:0]       words_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                chk("write_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                chk("write_data", mem_wdata, exp_data_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int waited = 0;
        if (gap > 0) begin
            while ($urandom_range(99) < gap) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        start      = with_start;
        while (byte_ready !== 1'b1) begin
            @(negedge clk);
            start = 1'b0;
            waited++;
            if (waited > 100) begin
                chk("byte_accept_timeout", 32'd0, 32'd1);
                byte_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("start_byte_ready", 32'(byte_ready), 32'd1);
        chk("start_clears_done", 32'(done), 32'd0);
        chk("start_clears_error", 32'(error), 32'd0);
    endtask

    task automatic drain_check(input string tag);
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_extra_not_ready"}, 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    // Reference: a valid frame writes word i to address i; status depends on length and checksum.
    task automatic do_load(input int n, input int gap, input int start_at, input bit bad_csum, input string tag);
        bit         len_bad = (n == 0) || (n > DEPTH);
        bit         ok;
        logic [7:0] cs = 8'd0;
        logic [7:0] b;
        int         bi = 0;
        pulse_start();
        send_byte(n[7:0], gap, start_at == bi); bi++;
        send_byte(n[15:8], gap, start_at == bi); bi++;
        if (len_bad) begin
            chk({tag, "_len_error"}, 32'(error), 32'd1);
            chk({tag, "_len_done"}, 32'(done), 32'd0);
            chk({tag, "_len_busy"}, 32'(busy), 32'd0);
            drain_check(tag);
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(i[ADDR_W-1:0]);
            exp_data_q.push_back(words_q[i]);
            for (int k = 0; k < 4; k++) begin
                b  = words_q[i][8*k +: 8];
                cs = cs ^ b;
                send_byte(b, gap, start_at == bi);
                bi++;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? ~cs : cs, gap, start_at == bi);
        ok = !bad_csum;
`else
        ok = 1'b1;
`endif
        chk({tag, "_done"}, 32'(done), 32'(ok));
        chk({tag, "_error"}, 32'(error), 32'(!ok));
        chk({tag, "_cpu_hold_low"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        drain_check(tag);
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_byte_ready", 32'(byte_ready), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_not_ready", 32'(byte_ready), 32'd0);

        words_q.delete();
        words_q.push_back(32'h0010_0513);
        words_q.push_back(32'h0020_0593);
        do_load(2, 0, -1, 1'b0, "n2");

        do_load(0, 0, -1, 1'b0, "len0");
        do_load(DEPTH + 1, 0, -1, 1'b0, "len4097");

        rand_words(3);
        do_load(3, 0, -1, 1'b0, "n3_gapless");
        do_load(3, 50, -1, 1'b0, "n3_gaps");

        // Reset in the middle of the second word: only address 0 was written.
        rand_words(2);
        pulse_start();
        send_byte(8'd2, 0, 1'b0);
        send_byte(8'd0, 0, 1'b0);
        exp_addr_q.push_back('0);
        exp_data_q.push_back(words_q[0]);
        for (int j = 0; j < 6; j++) send_byte(words_q[j / 4][8*(j % 4) +: 8], 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_byte_ready", 32'(byte_ready), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        chk("abort_writes_seen", 32'(exp_addr_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_load(2, 0, -1, 1'b0, "after_abort");

        rand_words(2);
        do_load(2, 0, 1, 1'b0, "start_in_len");
        do_load(2, 0, 5, 1'b0, "start_in_data");
        do_load(2, 30, -1, 1'b0, "reload_from_done");

`ifdef IMEM_LOADER_CHECKSUM_EN
        words_q.delete();
        words_q.push_back(32'h0000_0013);
        do_load(1, 0, -1, 1'b0, "csum_good");
        do_load(1, 0, -1, 1'b1, "csum_bad");
        rand_words(4);
        do_load(4, 40, -1, 1'b1, "csum_bad_rand");
`endif

        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(6, 1);
            rand_words(n);
            do_load(n, $urandom_range(60, 0), -1, 1'b0, "random");
        end

        rand_words(DEPTH);
        do_load(DEPTH, 0, -1, 1'b0, "full_depth");
        rand_words(1);
        do_load(1, 0, -1, 1'b0, "after_full");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
